// File: rtl/hazard_control_unit.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes and
// data-memory wait freezes with timeout abort, plus saturating stall/flush counters.
module hazard_control_unit #(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       IF_ID_RS1,
   input  logic [4:0]       IF_ID_RS2,
   input  logic             IF_ID_UsesRS2,
   input  logic [4:0]       ID_EX_Rd,
   input  logic             ID_EX_MemRead,
   input  logic             EX_BranchTaken,
   input  logic             EX_MEM_MemReq,
   input  logic             DMEM_Ready,
   output logic             PCWrite,
   output logic             IF_ID_Write,
   output logic             IF_ID_Flush,
   output logic             ID_EX_Flush,
   output logic             Pipe_Hold,
   output logic             MEM_WB_Bubble,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic {RUN, MEM_WAIT} state_t;

   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t           state_reg, state_next;
   logic [7:0]       wait_cnt_reg, wait_cnt_next;
   logic             mem_timeout_reg;
   logic [CNT_W-1:0] stall_count_reg, flush_count_reg;

   logic mem_stall;
   logic abort;
   logic load_use;

   assign mem_stall = EX_MEM_MemReq & ~DMEM_Ready;
   assign abort     = (state_reg == MEM_WAIT) & mem_stall & (wait_cnt_reg == WAIT_LAST);
   assign load_use  = ID_EX_MemRead & (ID_EX_Rd != 5'd0) &
                      ((ID_EX_Rd == IF_ID_RS1) | (IF_ID_UsesRS2 & (ID_EX_Rd == IF_ID_RS2)));

   always_comb begin
      PCWrite       = 1'b1;
      IF_ID_Write   = 1'b1;
      IF_ID_Flush   = 1'b0;
      ID_EX_Flush   = 1'b0;
      Pipe_Hold     = 1'b0;
      MEM_WB_Bubble = 1'b0;
      if (reset) begin
         PCWrite       = 1'b0;
         IF_ID_Write   = 1'b0;
         IF_ID_Flush   = 1'b1;
         ID_EX_Flush   = 1'b1;
         MEM_WB_Bubble = 1'b1;
      end else if (mem_stall && !abort) begin
         // Whole pipe frozen; branch and load-use re-evaluate once memory answers.
         PCWrite       = 1'b0;
         IF_ID_Write   = 1'b0;
         Pipe_Hold     = 1'b1;
         MEM_WB_Bubble = 1'b1;
      end else begin
         MEM_WB_Bubble = abort;
         if (EX_BranchTaken) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
         end else if (load_use) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
         end
      end
   end

   always_comb begin
      state_next    = RUN;
      wait_cnt_next = 8'd0;
      if (mem_stall && !abort) begin
         state_next    = MEM_WAIT;
         wait_cnt_next = (state_reg == RUN) ? 8'd1 : wait_cnt_reg + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= RUN;
         wait_cnt_reg    <= 8'd0;
         mem_timeout_reg <= 1'b0;
         stall_count_reg <= '0;
         flush_count_reg <= '0;
      end else begin
         state_reg       <= state_next;
         wait_cnt_reg    <= wait_cnt_next;
         mem_timeout_reg <= mem_timeout_reg | abort;
         if (!PCWrite && stall_count_reg != {CNT_W{1'b1}})
            stall_count_reg <= stall_count_reg + 1'b1;
         if (IF_ID_Flush && flush_count_reg != {CNT_W{1'b1}})
            flush_count_reg <= flush_count_reg + 1'b1;
      end
   end

   assign mem_timeout = mem_timeout_reg;
   assign stall_count = stall_count_reg;
   assign flush_count = flush_count_reg;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed scoreboard bench for hazard_control_unit (CNT_W=2, MEM_TIMEOUT=4):
// stimulus pushes hand-computed expectations, a negedge monitor pops and compares.
module tb_hazard_control_unit;

   localparam int CNT_W = 2;

   // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Pipe_Hold, MEM_WB_Bubble}
   localparam logic [5:0] C_RST = 6'b001101;
   localparam logic [5:0] C_DEF = 6'b110000;
   localparam logic [5:0] C_BR  = 6'b111100;
   localparam logic [5:0] C_LU  = 6'b000100;
   localparam logic [5:0] C_MS  = 6'b000011;
   localparam logic [5:0] C_TO  = 6'b110001;

   typedef struct packed {
      logic [5:0]       ctrl;
      logic             to;
      logic [CNT_W-1:0] sc;
      logic [CNT_W-1:0] fc;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset;
   logic [4:0]       IF_ID_RS1, IF_ID_RS2, ID_EX_Rd;
   logic             IF_ID_UsesRS2, ID_EX_MemRead, EX_BranchTaken, EX_MEM_MemReq, DMEM_Ready;
   logic             PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Pipe_Hold, MEM_WB_Bubble;
   logic             mem_timeout;
   logic [CNT_W-1:0] stall_count, flush_count;

   exp_t  sb_q[$];
   string name_q[$];
   int    n_tests = 0;
   int    n_fail  = 0;

   hazard_control_unit #(.CNT_W(CNT_W), .MEM_TIMEOUT(4)) u_dut (
      .clk(clk), .reset(reset),
      .IF_ID_RS1(IF_ID_RS1), .IF_ID_RS2(IF_ID_RS2), .IF_ID_UsesRS2(IF_ID_UsesRS2),
      .ID_EX_Rd(ID_EX_Rd), .ID_EX_MemRead(ID_EX_MemRead),
      .EX_BranchTaken(EX_BranchTaken), .EX_MEM_MemReq(EX_MEM_MemReq), .DMEM_Ready(DMEM_Ready),
      .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
      .ID_EX_Flush(ID_EX_Flush), .Pipe_Hold(Pipe_Hold), .MEM_WB_Bubble(MEM_WB_Bubble),
      .mem_timeout(mem_timeout), .stall_count(stall_count), .flush_count(flush_count)
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs just after the edge; counters expected are the pre-edge values.
   task automatic step(input string nm, input logic rst,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic use2,
                       input logic [4:0] rd, input logic mrd, input logic br,
                       input logic mreq, input logic rdy,
                       input logic [5:0] ctrl, input logic to,
                       input logic [CNT_W-1:0] sc, input logic [CNT_W-1:0] fc);
      exp_t e;
      @(posedge clk);
      #1;
      reset = rst; IF_ID_RS1 = rs1; IF_ID_RS2 = rs2; IF_ID_UsesRS2 = use2;
      ID_EX_Rd = rd; ID_EX_MemRead = mrd; EX_BranchTaken = br;
      EX_MEM_MemReq = mreq; DMEM_Ready = rdy;
      e.ctrl = ctrl; e.to = to; e.sc = sc; e.fc = fc;
      sb_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic idle(input string nm, input logic to, input logic [CNT_W-1:0] sc,
                       input logic [CNT_W-1:0] fc);
      step(nm, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_DEF, to, sc, fc);
   endtask

   task automatic do_reset(input string nm, input logic to, input logic [CNT_W-1:0] sc,
                           input logic [CNT_W-1:0] fc);
      step(nm, 1, 0, 0, 0, 0, 0, 0, 0, 1, C_RST, to, sc, fc);
   endtask

   // memory stall: MemReq=1, Ready=0, optional branch alongside
   task automatic mwait(input string nm, input logic br, input logic [5:0] ctrl,
                        input logic to, input logic [CNT_W-1:0] sc, input logic [CNT_W-1:0] fc);
      step(nm, 0, 0, 0, 0, 0, 0, br, 1, 0, ctrl, to, sc, fc);
   endtask

   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t  e;
         exp_t  a;
         string nm;
         e  = sb_q.pop_front();
         nm = name_q.pop_front();
         a.ctrl = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Pipe_Hold, MEM_WB_Bubble};
         a.to = mem_timeout; a.sc = stall_count; a.fc = flush_count;
         n_tests++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got ctrl=%b to=%b sc=%0d fc=%0d, expected ctrl=%b to=%b sc=%0d fc=%0d",
                     nm, a.ctrl, a.to, a.sc, a.fc, e.ctrl, e.to, e.sc, e.fc);
         end else begin
            $display("[TB] ok %s ctrl=%b to=%b sc=%0d fc=%0d", nm, a.ctrl, a.to, a.sc, a.fc);
         end
      end
   end

   initial begin
      reset = 1'b1; IF_ID_RS1 = 0; IF_ID_RS2 = 0; IF_ID_UsesRS2 = 0; ID_EX_Rd = 0;
      ID_EX_MemRead = 0; EX_BranchTaken = 0; EX_MEM_MemReq = 0; DMEM_Ready = 1;
      repeat (2) @(posedge clk);

      // reset values, load-use detection and its corner cases
      do_reset("reset", 0, 0, 0);
      idle("idle", 0, 0, 0);
      step("lu_rs1",       0, 5, 0, 0, 5, 1, 0, 0, 1, C_LU,  0, 0, 0);
      step("lu_bubbled",   0, 5, 0, 0, 5, 0, 0, 0, 1, C_DEF, 0, 1, 0);
      step("lu_rd0",       0, 0, 0, 0, 0, 1, 0, 0, 1, C_DEF, 0, 1, 0);
      step("lu_rs2_nouse", 0, 1, 7, 0, 7, 1, 0, 0, 1, C_DEF, 0, 1, 0);
      step("lu_rs2_use",   0, 1, 7, 1, 7, 1, 0, 0, 1, C_LU,  0, 1, 0);
      step("br_over_lu",   0, 5, 0, 0, 5, 1, 1, 0, 1, C_BR,  0, 2, 0);
      idle("after_br", 0, 2, 1);

      // memory wait of 3 cycles with a branch pending while frozen
      do_reset("reset2", 0, 2, 1);
      mwait("mem_w1", 0, C_MS, 0, 0, 0);
      mwait("mem_w2_br", 1, C_MS, 0, 1, 0);
      mwait("mem_w3_br", 1, C_MS, 0, 2, 0);
      step("mem_ready_br", 0, 0, 0, 0, 0, 0, 1, 1, 1, C_BR, 0, 3, 0);
      idle("post_mem", 0, 3, 1);

      // timeout abort after MEM_TIMEOUT-1 frozen cycles, flag sticky
      do_reset("reset3", 0, 3, 1);
      mwait("to_w1", 0, C_MS, 0, 0, 0);
      mwait("to_w2", 0, C_MS, 0, 1, 0);
      mwait("to_w3", 0, C_MS, 0, 2, 0);
      mwait("to_abort", 0, C_TO, 0, 3, 0);
      idle("to_sticky1", 1, 3, 0);
      idle("to_sticky2", 1, 3, 0);

      // reset honoured in the middle of MEM_WAIT, then a full fresh wait window
      mwait("rst_pre", 0, C_MS, 1, 3, 0);
      step("rst_mid", 1, 0, 0, 0, 0, 0, 0, 1, 0, C_RST, 1, 3, 0);
      mwait("rw_w1", 0, C_MS, 0, 0, 0);
      mwait("rw_w2", 0, C_MS, 0, 1, 0);
      mwait("rw_w3", 0, C_MS, 0, 2, 0);
      mwait("rw_abort", 0, C_TO, 0, 3, 0);
      idle("rw_after", 1, 3, 0);

      // saturation: five load-use stalls into a 2-bit counter
      do_reset("reset4", 1, 3, 0);
      for (int i = 0; i < 5; i++)
         step($sformatf("sat_lu%0d", i), 0, 9, 0, 0, 9, 1, 0, 0, 1, C_LU, 0,
              (i < 3) ? CNT_W'(i) : CNT_W'(3), 0);
      idle("sat_hold", 0, 3, 0);

      repeat (3) @(negedge clk);
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending, expected 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
